serial_cmd_decoder: RTL

Byte-stream command decoder between the serial byte receiver and the HyperRAM controller. Assembles frames of one command byte plus `DATA_BYTES` payload bytes and decodes them into the address and write-data registers, a start pulse, and readback responses. Responses are serialised MSB-first onto a byte output with a valid/ready handshake. This block generalises the fixed 32-bit, 5-byte command parser with a configurable payload width, a read-data path, error reporting and an optional inter-byte timeout.

---
 rtl/serial_cmd_decoder_if.sv | 33 +++
 rtl/serial_cmd_decoder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/serial_cmd_decoder_if.sv
// Handshake/bus bundle for serial_cmd_decoder.
// slave = decoder side, master = byte source / controller side.
interface serial_cmd_decoder_if #(
  parameter int W = 32
);
  logic         rx_valid;
  logic [7:0]   rx_data;
  logic [W-1:0] rd_data;
  logic         tx_ready;
  logic [W-1:0] addr;
  logic [W-1:0] wr_data;
  logic         start;
  logic         start_wr;
  logic         tx_valid;
  logic [7:0]   tx_data;
  logic         cmd_err;
  logic         overrun;
  logic         frame_err;

  modport slave (
    input  rx_valid, rx_data, rd_data, tx_ready,
    output addr, wr_data, start, start_wr,
    output tx_valid, tx_data,
    output cmd_err, overrun, frame_err
  );

  modport master (
    output rx_valid, rx_data, rd_data, tx_ready,
    input  addr, wr_data, start, start_wr,
    input  tx_valid, tx_data,
    input  cmd_err, overrun, frame_err
  );
endinterface

// File: rtl/serial_cmd_decoder.sv
// Byte-stream command decoder: frames of 1 cmd + DATA_BYTES payload
// bytes set addr/wr_data, pulse start, and serialise read responses.
// Ports: clk, reset (async, active-high), bus (serial_cmd_decoder_if.slave):
//   rx_valid/rx_data in, rd_data in, addr/wr_data/start/start_wr out,
//   tx_valid/tx_data out with tx_ready in, cmd_err/overrun/frame_err out.
// Optional feature: define SERIAL_CMD_TIMEOUT_EN for the inter-byte
// timeout that discards partial frames after TIMEOUT_CYCLES idle cycles.
module serial_cmd_decoder #(
  parameter int DATA_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_cmd_decoder_if.slave  bus
);
  localparam int W  = 8 * DATA_BYTES;
  localparam int CW = $clog2(DATA_BYTES + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_BYTES);

  logic [CW-1:0] r_cnt;
  logic [7:0]    r_cmd;
  logic [W-1:0]  r_pay;
  logic [W-1:0]  r_addr;
  logic [W-1:0]  r_wdata;
  logic          r_start;
  logic          r_start_wr;
  logic          r_tx_valid;
  logic [W-1:0]  r_sh;
  logic [CW-1:0] r_tx_cnt;
  logic          r_cmd_err;
  logic          r_overrun;
  logic          r_frame_err;

  logic [W-1:0]  w_pay;
  logic          w_done;
  logic          w_hs;
  logic          w_resp_en;
  logic          w_unk;
  logic [W-1:0]  w_resp;
  logic          w_expire;

  // Payload as it will look once the current byte is shifted in.
  assign w_pay  = (r_pay << 8) | W'(bus.rx_data);
  assign w_done = bus.rx_valid && (r_cnt == LAST);
  assign w_hs   = r_tx_valid && bus.tx_ready;

  always_comb begin
    w_resp_en = 1'b0;
    w_unk     = 1'b0;
    w_resp    = '0;
    case (r_cmd)
      8'h01, 8'h02, 8'h04: ;
      8'h03: begin
        w_resp_en = 1'b1;
        w_resp    = r_addr;
      end
      8'h05: begin
        w_resp_en = 1'b1;
        w_resp    = bus.rd_data;
      end
      default: begin
        w_resp_en = 1'b1;
        w_unk     = 1'b1;
      end
    endcase
  end

`ifdef SERIAL_CMD_TIMEOUT_EN
  localparam int IW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

  logic [IW-1:0] r_idle;

  // Expires on the TIMEOUT_CYCLES-th consecutive idle edge of a partial frame.
  assign w_expire = !bus.rx_valid && (r_cnt != '0) && (r_idle == IDLE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idle <= '0;
    end else if (bus.rx_valid || (r_cnt == '0) || w_expire) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + IW'(1);
    end
  end
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_cmd       <= '0;
      r_pay       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_start     <= 1'b0;
      r_start_wr  <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_start     <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= w_expire;
      if (bus.rx_valid) begin
        if (r_cnt == '0) begin
          r_cmd <= bus.rx_data;
        end else begin
          r_pay <= w_pay;
        end
        r_cnt <= w_done ? '0 : r_cnt + CW'(1);
      end else if (w_expire) begin
        r_cnt <= '0;
        r_pay <= '0;
      end
      if (w_done) begin
        case (r_cmd)
          8'h01: r_addr <= w_pay;
          8'h02: r_wdata <= w_pay;
          8'h04: begin
            r_start    <= 1'b1;
            r_start_wr <= w_pay[0];
          end
          default: ;
        endcase
        r_cmd_err <= w_unk;
        // A response arriving while one is still in flight is dropped.
        r_overrun <= w_resp_en && r_tx_valid;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_valid <= 1'b0;
      r_sh       <= '0;
      r_tx_cnt   <= '0;
    end else if (w_done && w_resp_en && !r_tx_valid) begin
      r_tx_valid <= 1'b1;
      r_sh       <= w_resp;
      r_tx_cnt   <= LAST;
    end else if (w_hs) begin
      r_sh       <= r_sh << 8;
      r_tx_cnt   <= r_tx_cnt - CW'(1);
      r_tx_valid <= (r_tx_cnt != CW'(1));
    end
  end

  assign bus.addr      = r_addr;
  assign bus.wr_data   = r_wdata;
  assign bus.start     = r_start;
  assign bus.start_wr  = r_start_wr;
  assign bus.tx_valid  = r_tx_valid;
  assign bus.tx_data   = r_sh[W-1 -: 8];
  assign bus.cmd_err   = r_cmd_err;
  assign bus.overrun   = r_overrun;
  assign bus.frame_err = r_frame_err;
endmodule
